multicycle_ctrl: RTL and testbench

Multicycle main controller for the processor. Sequences each instruction through the fetch, decode, execute, memory and writeback steps, and drives the datapath select lines. Produces the raw `flagUpdate`, `PCS`, `regW` and `memWriteSrc` requests that the conditional logic qualifies with the latched zero flag. Also stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 152 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller/datapath interface for the multicycle controller
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       op;
    logic [5:0]       funct;
    logic             memReady;
    logic             pcWrite;
    logic             irWrite;
    logic             adrSrc;
    logic             aluSrcA;
    logic [1:0]       aluSrcB;
    logic [1:0]       resultSrc;
    logic [1:0]       immSrc;
    logic [2:0]       aluControl;
    logic             flagUpdate;
    logic             PCS;
    logic             regW;
    logic             memWriteSrc;
    logic             halted;
    logic [CNT_W-1:0] instrCount;

    modport master (
        input  op, funct, memReady,
        output pcWrite, irWrite, adrSrc, aluSrcA, aluSrcB, resultSrc, immSrc,
               aluControl, flagUpdate, PCS, regW, memWriteSrc, halted, instrCount
    );

    modport slave (
        output op, funct, memReady,
        input  pcWrite, irWrite, adrSrc, aluSrcA, aluSrcB, resultSrc, immSrc,
               aluControl, flagUpdate, PCS, regW, memWriteSrc, halted, instrCount
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle main controller FSM with retired-instruction counter
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_ctrl_if.master    bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXECUTER = 4'd2,
        S_EXECUTEI = 4'd3,
        S_ALUWB    = 4'd4,
        S_MEMADR   = 4'd5,
        S_MEMREAD  = 4'd6,
        S_MEMWB    = 4'd7,
        S_MEMWRITE = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    state_t           r_state;
    state_t           w_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;
    logic [2:0]       w_alu_op;
    logic             w_cmd_wr;
    logic [3:0]       w_cmd;

    // Decoding from FETCH while reset is high keeps every request quiet during reset.
    assign w_state = reset ? S_FETCH : r_state;
    assign w_cmd   = bus.funct[4:1];

    always_comb begin
        w_alu_op = 3'b000;
        w_cmd_wr = 1'b0;
        case (w_cmd)
            4'b0100: begin w_alu_op = 3'b000; w_cmd_wr = 1'b1; end
            4'b0010: begin w_alu_op = 3'b001; w_cmd_wr = 1'b1; end
            4'b1010: begin w_alu_op = 3'b001; w_cmd_wr = 1'b0; end
            4'b0000: begin w_alu_op = 3'b010; w_cmd_wr = 1'b1; end
            4'b1100: begin w_alu_op = 3'b011; w_cmd_wr = 1'b1; end
            default: begin w_alu_op = 3'b000; w_cmd_wr = 1'b0; end
        endcase
    end

    always_comb begin
        w_next          = w_state;
        w_retire        = 1'b0;
        bus.pcWrite     = 1'b0;
        bus.irWrite     = 1'b0;
        bus.adrSrc      = 1'b0;
        bus.aluSrcA     = 1'b1;
        bus.aluSrcB     = 2'b10;
        bus.resultSrc   = 2'b10;
        bus.immSrc      = 2'b00;
        bus.aluControl  = 3'b000;
        bus.flagUpdate  = 1'b0;
        bus.PCS         = 1'b0;
        bus.regW        = 1'b0;
        bus.memWriteSrc = 1'b0;
        bus.halted      = 1'b0;
        case (w_state)
            S_FETCH: begin
                if (bus.memReady) begin
                    bus.irWrite = 1'b1;
                    bus.pcWrite = 1'b1;
                    w_next      = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.immSrc = (bus.op == 2'b11) ? 2'b00 : bus.op;
                case (bus.op)
                    2'b00:   w_next = bus.funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_HALT;
                endcase
            end
            S_EXECUTER: begin
                bus.aluSrcA    = 1'b0;
                bus.aluSrcB    = 2'b00;
                bus.aluControl = w_alu_op;
                bus.flagUpdate = bus.funct[0];
                w_next         = S_ALUWB;
            end
            S_EXECUTEI: begin
                bus.aluSrcA    = 1'b0;
                bus.aluSrcB    = 2'b01;
                bus.immSrc     = 2'b00;
                bus.aluControl = w_alu_op;
                bus.flagUpdate = bus.funct[0];
                w_next         = S_ALUWB;
            end
            S_ALUWB: begin
                bus.resultSrc = 2'b00;
                bus.regW      = w_cmd_wr;
                w_next        = S_FETCH;
                w_retire      = 1'b1;
            end
            S_MEMADR: begin
                bus.aluSrcA = 1'b0;
                bus.aluSrcB = 2'b01;
                bus.immSrc  = 2'b01;
                w_next      = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.adrSrc = 1'b1;
                if (bus.memReady) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                bus.resultSrc = 2'b01;
                bus.regW      = 1'b1;
                w_next        = S_FETCH;
                w_retire      = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adrSrc      = 1'b1;
                bus.memWriteSrc = 1'b1;
                if (bus.memReady) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_BRANCH: begin
                bus.aluSrcB = 2'b01;
                bus.immSrc  = 2'b10;
                bus.PCS     = 1'b1;
                w_next      = S_FETCH;
                w_retire    = 1'b1;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_count <= r_count + 1'b1;
        end
    end

    assign bus.instrCount = r_count;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    multicycle_ctrl_if #(.CNT_W(4)) bus ();
    multicycle_ctrl #(.CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic rdy);
        bus.op       = op;
        bus.funct    = funct;
        bus.memReady = rdy;
        #1;
    endtask

    task automatic test_reset;
        logic [13:0] v;
        reset = 1'b1;
        drive(2'b00, 6'b000000, 1'b0);
        tick();
        v = {bus.pcWrite, bus.irWrite, bus.adrSrc, bus.aluSrcA, bus.aluSrcB, bus.resultSrc,
             bus.flagUpdate, bus.PCS, bus.regW, bus.memWriteSrc, bus.halted, 1'b0};
        checks++;
        if (v !== 14'b0001_1010_0000_00) begin
            errors++; $display("FAIL reset_outputs got %b want %b", v, 14'b0001_1010_0000_00);
        end
        checks++;
        if (bus.instrCount !== 4'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", bus.instrCount);
        end
        drive(2'b00, 6'b000000, 1'b1);
        tick();
        tick();
        checks++;
        if (bus.instrCount !== 4'd0) begin
            errors++; $display("FAIL reset_rdy_count got %0d want 0", bus.instrCount);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.irWrite, bus.pcWrite} !== 2'b11) begin
            errors++; $display("FAIL first_irwrite got %b want 11", {bus.irWrite, bus.pcWrite});
        end
    endtask

    task automatic test_add_s;
        drive(2'b00, 6'b001001, 1'b1);
        tick();
        checks++;
        if ({bus.immSrc, bus.aluSrcB} !== 4'b0010) begin
            errors++; $display("FAIL add_decode got %b want 0010", {bus.immSrc, bus.aluSrcB});
        end
        tick();
        checks++;
        if ({bus.flagUpdate, bus.aluControl, bus.aluSrcA, bus.aluSrcB} !== 7'b1_000_0_00) begin
            errors++; $display("FAIL add_exec got %b want 1000000",
                               {bus.flagUpdate, bus.aluControl, bus.aluSrcA, bus.aluSrcB});
        end
        tick();
        checks++;
        if ({bus.regW, bus.resultSrc, bus.flagUpdate} !== 4'b1000) begin
            errors++; $display("FAIL add_wb got %b want 1000", {bus.regW, bus.resultSrc, bus.flagUpdate});
        end
        tick();
        checks++;
        if (bus.instrCount !== 4'd1 || bus.regW !== 1'b0) begin
            errors++; $display("FAIL add_retire got cnt=%0d regW=%b want cnt=1 regW=0",
                               bus.instrCount, bus.regW);
        end
    endtask

    task automatic test_cmp_imm;
        drive(2'b00, 6'b110101, 1'b1);
        tick();
        tick();
        checks++;
        if ({bus.aluSrcB, bus.aluControl, bus.immSrc, bus.flagUpdate} !== 8'b01_001_00_1) begin
            errors++; $display("FAIL cmp_exec got %b want 01001001",
                               {bus.aluSrcB, bus.aluControl, bus.immSrc, bus.flagUpdate});
        end
        tick();
        checks++;
        if ({bus.regW, bus.resultSrc} !== 3'b000) begin
            errors++; $display("FAIL cmp_wb got %b want 000", {bus.regW, bus.resultSrc});
        end
        tick();
        checks++;
        if (bus.instrCount !== 4'd2) begin
            errors++; $display("FAIL cmp_count got %0d want 2", bus.instrCount);
        end
    endtask

    task automatic test_load_wait;
        int n = 0;
        drive(2'b01, 6'b000001, 1'b1);
        tick();
        checks++;
        if (bus.immSrc !== 2'b01) begin
            errors++; $display("FAIL ld_decode_imm got %b want 01", bus.immSrc);
        end
        tick();
        checks++;
        if ({bus.aluSrcA, bus.aluSrcB, bus.immSrc, bus.aluControl} !== 8'b0_01_01_000) begin
            errors++; $display("FAIL ld_memadr got %b want 00101000",
                               {bus.aluSrcA, bus.aluSrcB, bus.immSrc, bus.aluControl});
        end
        bus.memReady = 1'b0;
        tick();
        for (int c = 0; c < 12; c++) begin
            bus.memReady = (c >= 3);
            #1;
            if (bus.adrSrc !== 1'b1) break;
            n++;
            tick();
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL ld_adrsrc_cycles got %0d want 4", n);
        end
        checks++;
        if ({bus.resultSrc, bus.regW} !== 3'b011) begin
            errors++; $display("FAIL ld_memwb got %b want 011", {bus.resultSrc, bus.regW});
        end
        tick();
        checks++;
        if (bus.regW !== 1'b0 || bus.instrCount !== 4'd3) begin
            errors++; $display("FAIL ld_retire got regW=%b cnt=%0d want regW=0 cnt=3",
                               bus.regW, bus.instrCount);
        end
    endtask

    task automatic test_store_branch;
        int n = 0;
        int pcs_n = 0;
        drive(2'b01, 6'b000000, 1'b1);
        tick();
        tick();
        bus.memReady = 1'b0;
        tick();
        for (int c = 0; c < 12; c++) begin
            bus.memReady = (c >= 1);
            #1;
            if (bus.memWriteSrc !== 1'b1) break;
            n++;
            tick();
        end
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL st_memwrite_cycles got %0d want 2", n);
        end
        checks++;
        if (bus.instrCount !== 4'd4) begin
            errors++; $display("FAIL st_count got %0d want 4", bus.instrCount);
        end
        drive(2'b10, 6'b000000, 1'b1);
        for (int c = 0; c < 4; c++) begin
            if (bus.PCS === 1'b1) begin
                pcs_n++;
                checks++;
                if ({bus.immSrc, bus.aluSrcA, bus.aluSrcB} !== 5'b10_1_01) begin
                    errors++; $display("FAIL br_selects got %b want 10101",
                                       {bus.immSrc, bus.aluSrcA, bus.aluSrcB});
                end
            end
            if (c < 3) tick();
        end
        checks++;
        if (pcs_n != 1) begin
            errors++; $display("FAIL br_pcs_pulses got %0d want 1", pcs_n);
        end
        checks++;
        if (bus.instrCount !== 4'd5) begin
            errors++; $display("FAIL br_count got %0d want 5", bus.instrCount);
        end
    endtask

    task automatic test_halt;
        drive(2'b11, 6'b000000, 1'b1);
        tick();
        tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({bus.halted, bus.pcWrite, bus.irWrite, bus.regW, bus.memWriteSrc, bus.PCS,
                 bus.flagUpdate} !== 7'b1000000) begin
                errors++; $display("FAIL halt_cycle%0d got %b want 1000000", c,
                    {bus.halted, bus.pcWrite, bus.irWrite, bus.regW, bus.memWriteSrc, bus.PCS,
                     bus.flagUpdate});
            end
            tick();
        end
        checks++;
        if (bus.instrCount !== 4'd5) begin
            errors++; $display("FAIL halt_count got %0d want 5", bus.instrCount);
        end
    endtask

    task automatic test_reset_abort;
        reset = 1'b1;
        drive(2'b01, 6'b000000, 1'b1);
        tick();
        reset = 1'b0;
        #1;
        tick();
        tick();
        bus.memReady = 1'b0;
        tick();
        checks++;
        if (bus.memWriteSrc !== 1'b1) begin
            errors++; $display("FAIL abort_in_memwrite got %b want 1", bus.memWriteSrc);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.memWriteSrc, bus.adrSrc, bus.regW} !== 3'b000) begin
            errors++; $display("FAIL abort_during_reset got %b want 000",
                               {bus.memWriteSrc, bus.adrSrc, bus.regW});
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.memWriteSrc, bus.regW, bus.irWrite, bus.instrCount} !== 7'b000_0000) begin
            errors++; $display("FAIL abort_after got %b want 0000000",
                               {bus.memWriteSrc, bus.regW, bus.irWrite, bus.instrCount});
        end
    endtask

    task automatic test_wrap;
        drive(2'b10, 6'b000000, 1'b0);
        tick();
        checks++;
        if ({bus.irWrite, bus.pcWrite, bus.adrSrc} !== 3'b000) begin
            errors++; $display("FAIL fetch_stall got %b want 000", {bus.irWrite, bus.pcWrite, bus.adrSrc});
        end
        bus.memReady = 1'b1;
        #1;
        checks++;
        if (bus.irWrite !== 1'b1) begin
            errors++; $display("FAIL fetch_resume got %b want 1", bus.irWrite);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            tick();
            tick();
            if (i == 15) begin
                checks++;
                if (bus.instrCount !== 4'd15) begin
                    errors++; $display("FAIL wrap_max got %0d want 15", bus.instrCount);
                end
            end
        end
        checks++;
        if (bus.instrCount !== 4'd0) begin
            errors++; $display("FAIL wrap_zero got %0d want 0", bus.instrCount);
        end
    endtask

    initial begin
        bus.op       = 2'b00;
        bus.funct    = 6'b000000;
        bus.memReady = 1'b0;
        @(negedge clk);
        test_reset();
        test_add_s();
        test_cmp_imm();
        test_load_wait();
        test_store_branch();
        test_halt();
        test_reset_abort();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
